bcp_ucq_ctrl: RTL and testbench
===============================

BCP_UCQ_CTRL -- requirements
Module: bcp_ucq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LIT_IDX_MAX, default from bcp_pkg, meaning the highest variable index.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port dec_valid, input, 1 bit: the top controller offers a decision literal.
REQ-006 SHALL have port dec_lit, input, lit_t: the decision literal, signed.
REQ-007 SHALL have port dec_ready, output, 1 bit: the decision is accepted this cycle.
REQ-008 SHALL have port imply_valid, input, 1 bit: the PE offers an implication.
REQ-009 SHALL have port imply_lit, input, lit_t: the implied literal.
REQ-010 SHALL have port pe_conflict, input, 1 bit: the PE reports a conflicting clause.
REQ-011 SHALL have port pe_idle, input, 1 bit: the PE has no clause in flight.
REQ-012 SHALL have port ucq_full, output, 1 bit: the FIFO is full; drives the PE UCQ_in_full.
REQ-013 SHALL have port ucq_empty, output, 1 bit: no literal is available; drives the PE UCQ_out_empty.
REQ-014 SHALL have port ucq_pop, input, 1 bit: the PE consumes the head literal.
REQ-015 SHALL have port lit_out, output, lit_t: the head literal, first-word-fall-through; 0 when empty.
REQ-016 SHALL have port backtrack, input, 1 bit: clear all assignments and queue contents.
REQ-017 SHALL have port conflict, output, 1 bit: sticky conflict flag.
REQ-018 SHALL have port state, output, ucq_state_t: the current FSM state.

Function
REQ-019 SHALL implement an FSM with states IDLE, PROP, CONFL and CLEAR.
REQ-020 In IDLE, dec_ready SHALL equal dec_valid; the decision is enqueued and the FSM enters PROP.
REQ-021 In PROP, imply_valid && !ucq_full SHALL accept imply_lit; an implication offered while full is not consumed (the PE stalls).
REQ-022 Each accepted literal L SHALL be filtered against the assigned[1..LIT_IDX_MAX] and polarity bitmaps: if |L| is unassigned, set assigned and polarity=(L>0) and enqueue L; if assigned with the same polarity, drop L silently; if assigned with the opposite polarity, raise conflict and enter CONFL.
REQ-023 A literal with L==0 or |L|>LIT_IDX_MAX SHALL be ignored, with no state change.
REQ-024 The bitmap SHALL update in the acceptance cycle, so a duplicate of L offered in the next cycle is dropped.
REQ-025 At most one push per cycle SHALL occur, and dec_ready SHALL be 0 outside IDLE.
REQ-026 A push and a pop in the same cycle SHALL leave count unchanged; a pop when empty SHALL be ignored.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide; full is count==DEPTH and empty is count==0.
REQ-028 Latency: a literal pushed into an empty FIFO SHALL appear on lit_out, with ucq_empty=0, in the next cycle.
REQ-029 PROP SHALL transition to IDLE when ucq_empty && pe_idle && !imply_valid; the bitmap persists.
REQ-030 pe_conflict in PROP SHALL cause a transition to CONFL in the next cycle.
REQ-031 On entering CONFL the FIFO SHALL be flushed, ucq_empty forced to 1 and pushes ignored; conflict=1 until backtrack.
REQ-032 backtrack in any state SHALL cause a transition to CLEAR in the next cycle.
REQ-033 CLEAR SHALL zero the bitmaps and pointers and clear conflict, then transition to IDLE.
REQ-034 backtrack SHALL take priority over all pushes, pops and conflicts in the same cycle.
REQ-035 A conflicting push and a pe_conflict in the same cycle SHALL produce a single entry into CONFL.

Reset
REQ-036 While rst_n==0 at the clock edge: state=IDLE, pointers=0, count=0, bitmaps=0, conflict=0.
REQ-037 During reset the outputs SHALL be ucq_empty=1, ucq_full=0, lit_out=0 and dec_ready=0.
REQ-038 A reset mid-PROP SHALL discard all queued literals, with no residue after release.

Structure
REQ-039 bcp_pkg SHALL contain lit_t, LIT_W ($clog2(LIT_IDX_MAX)+1), LIT_IDX_MAX, CLA_LENGTH and ucq_state_t.
REQ-040 The FIFO SHALL be a sub-module ucq_fifo with parameters DEPTH and lit_t, providing push, pop, flush, full, empty and a FWFT head.
REQ-041 The filtering, bitmap and FSM logic SHALL reside in bcp_ucq_ctrl.

Verification
REQ-042 Decision: dec_lit=+3 in IDLE -> dec_ready=1; next cycle lit_out=+3, ucq_empty=0, state=PROP.
REQ-043 Duplicate drop: imply -5 on two consecutive cycles -> exactly one -5 enqueued; count=1.
REQ-044 Opposite polarity: decision +2, then imply -2 -> conflict=1, state=CONFL and ucq_empty=1 next cycle; a later backtrack -> CLEAR then IDLE, with conflict=0 and assigned[2]=0.
REQ-045 Full boundary (DEPTH=4): push +1..+4 with no pops -> ucq_full=1; imply +5 is held; pop one -> +5 is accepted next cycle; lit_out order is +1,+2,+3,+4,+5.
REQ-046 Simultaneous events: push and pop in the same cycle at count=2 -> count stays 2; backtrack together with imply +7 -> +7 is not enqueued and state=CLEAR.
REQ-047 Reset mid-PROP with 3 queued literals -> after release ucq_empty=1, state=IDLE, and +1 is accepted as a fresh decision.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP unit-clause-queue slice.
package bcp_pkg;

    localparam int LIT_IDX_MAX = 31;
    localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;
    localparam int CLA_LENGTH  = 3;

    // Signed literal: sign is polarity, magnitude is the variable index.
    typedef logic signed [LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROP  = 2'd1,
        CONFL = 2'd2,
        CLEAR = 2'd3
    } ucq_state_t;

    // Variable index of a literal, computed wide so the most negative
    // literal does not overflow.
    function automatic int unsigned lit_mag(input lit_t lit);
        int v;
        v = int'(lit);
        if (v < 0) begin
            v = -v;
        end
        return unsigned'(v);
    endfunction

endpackage

// File: rtl/ucq_fifo.sv
// First-word-fall-through FIFO holding literals waiting for the PE.
module ucq_fifo #(
    parameter int  DEPTH = 16,
    parameter type lit_t = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  lit_t push_data,
    input  logic pop,
    input  logic flush,
    output logic full,
    output logic empty,
    output lit_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    lit_t             mem_q [DEPTH];
    lit_t             mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count/storage; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bcp_ucq_ctrl.sv
// Unit-clause queue controller: filters decisions/implications against the
// assignment bitmaps, feeds the PE through a FIFO and tracks conflicts.
module bcp_ucq_ctrl
    import bcp_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int LIT_IDX_MAX = bcp_pkg::LIT_IDX_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_valid,
    input  lit_t       dec_lit,
    output logic       dec_ready,
    input  logic       imply_valid,
    input  lit_t       imply_lit,
    input  logic       pe_conflict,
    input  logic       pe_idle,
    output logic       ucq_full,
    output logic       ucq_empty,
    input  logic       ucq_pop,
    output lit_t       lit_out,
    input  logic       backtrack,
    output logic       conflict,
    output ucq_state_t state
);

    localparam int IDX_W = $clog2(LIT_IDX_MAX + 1);

    ucq_state_t             state_q, state_d;
    logic                   conflict_q, conflict_d;
    logic [LIT_IDX_MAX:1]   assigned_q, assigned_d;
    logic [LIT_IDX_MAX:1]   polarity_q, polarity_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    lit_t                   fifo_head;

    logic                   cand_valid;
    lit_t                   cand_lit;
    int unsigned            cand_mag;
    logic                   cand_in_range;
    logic [IDX_W-1:0]       cand_idx;
    logic                   cand_pos;
    logic                   lit_conflict;

    ucq_fifo #(
        .DEPTH (DEPTH),
        .lit_t (lit_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (cand_lit),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // The queue looks empty while held in reset, in conflict and while clearing.
    assign ucq_empty = !rst_n || fifo_empty || (state_q == CONFL) || (state_q == CLEAR);
    assign ucq_full  = rst_n && fifo_full;
    assign lit_out   = ucq_empty ? '0 : fifo_head;
    assign dec_ready = rst_n && (state_q == IDLE) && dec_valid && !backtrack;
    assign conflict  = conflict_q;
    assign state     = state_q;

    // Literal filtering, bitmap update, FIFO control and next-state selection.
    always_comb begin
        state_d       = state_q;
        conflict_d    = conflict_q;
        assigned_d    = assigned_q;
        polarity_d    = polarity_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        lit_conflict  = 1'b0;
        cand_valid    = 1'b0;
        cand_lit      = '0;

        case (state_q)
            IDLE: begin
                cand_valid = dec_valid;
                cand_lit   = dec_lit;
            end
            PROP: begin
                cand_valid = imply_valid && !fifo_full;
                cand_lit   = imply_lit;
            end
            default: ;
        endcase

        cand_mag      = lit_mag(cand_lit);
        cand_in_range = (cand_mag >= 1) && (cand_mag <= LIT_IDX_MAX);
        cand_idx      = cand_mag[IDX_W-1:0];
        cand_pos      = !cand_lit[$bits(lit_t)-1];

        if (backtrack) begin
            fifo_flush = 1'b1;
            state_d    = CLEAR;
        end else begin
            case (state_q)
                IDLE, PROP: begin
                    fifo_pop = ucq_pop;
                    if (cand_valid && cand_in_range) begin
                        if (!assigned_q[cand_idx]) begin
                            assigned_d[cand_idx] = 1'b1;
                            polarity_d[cand_idx] = cand_pos;
                            fifo_push            = 1'b1;
                        end else if (polarity_q[cand_idx] != cand_pos) begin
                            lit_conflict = 1'b1;
                        end
                    end
                    if (lit_conflict || ((state_q == PROP) && pe_conflict)) begin
                        fifo_push  = 1'b0;
                        fifo_pop   = 1'b0;
                        fifo_flush = 1'b1;
                        conflict_d = 1'b1;
                        state_d    = CONFL;
                    end else if (state_q == IDLE) begin
                        if (cand_valid && cand_in_range) begin
                            state_d = PROP;
                        end
                    end else if (fifo_empty && pe_idle && !imply_valid) begin
                        state_d = IDLE;
                    end
                end
                CONFL: begin
                    fifo_flush = 1'b1;
                end
                CLEAR: begin
                    fifo_flush = 1'b1;
                    assigned_d = '0;
                    polarity_d = '0;
                    conflict_d = 1'b0;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state, sticky conflict flag and assignment bitmaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            conflict_q <= 1'b0;
            assigned_q <= '0;
            polarity_q <= '0;
        end else begin
            state_q    <= state_d;
            conflict_q <= conflict_d;
            assigned_q <= assigned_d;
            polarity_q <= polarity_d;
        end
    end

endmodule

// File: tb/tb_bcp_ucq_ctrl.sv
// Self-checking bench for bcp_ucq_ctrl with a scoreboard of expected head literals.
module tb_bcp_ucq_ctrl;
    import bcp_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       dec_valid;
    lit_t       dec_lit;
    logic       dec_ready;
    logic       imply_valid;
    lit_t       imply_lit;
    logic       pe_conflict;
    logic       pe_idle;
    logic       ucq_full;
    logic       ucq_empty;
    logic       ucq_pop;
    lit_t       lit_out;
    logic       backtrack;
    logic       conflict;
    ucq_state_t state;

    int checkCount = 0;
    int passCount  = 0;
    int expQ[$];

    bcp_ucq_ctrl #(
        .DEPTH       (DEPTH),
        .LIT_IDX_MAX (LIT_IDX_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_lit     (dec_lit),
        .dec_ready   (dec_ready),
        .imply_valid (imply_valid),
        .imply_lit   (imply_lit),
        .pe_conflict (pe_conflict),
        .pe_idle     (pe_idle),
        .ucq_full    (ucq_full),
        .ucq_empty   (ucq_empty),
        .ucq_pop     (ucq_pop),
        .lit_out     (lit_out),
        .backtrack   (backtrack),
        .conflict    (conflict),
        .state       (state)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input int dl, input logic iv, input int il,
                                 input logic bt, input logic pc);
        dec_valid   = dv;
        dec_lit     = lit_t'(dl);
        imply_valid = iv;
        imply_lit   = lit_t'(il);
        backtrack   = bt;
        pe_conflict = pc;
    endtask

    // Compare the head against the oldest scoreboard entry, then consume it.
    task automatic popExpect(input string tag);
        checkOutput({tag, "_nonempty"}, int'(ucq_empty), 0);
        if (expQ.size() > 0) begin
            checkOutput(tag, int'(lit_out), expQ.pop_front());
        end else begin
            checkOutput({tag, "_sb_empty"}, int'(ucq_empty), 1);
        end
        ucq_pop = 1'b1;
        tick();
        ucq_pop = 1'b0;
    endtask

    task automatic doBacktrack();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expQ.delete();
    endtask

    // Directed sequence covering decision, filtering, full, conflict and reset cases.
    initial begin
        rst_n   = 1'b0;
        ucq_pop = 1'b0;
        pe_idle = 1'b0;
        applyStimulus(1, 3, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_dec_ready", int'(dec_ready), 0);
        checkOutput("rst_empty", int'(ucq_empty), 1);
        checkOutput("rst_full", int'(ucq_full), 0);
        checkOutput("rst_lit_out", int'(lit_out), 0);
        checkOutput("rst_state", int'(state), int'(IDLE));
        checkOutput("rst_conflict", int'(conflict), 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        // Decision +3 is taken immediately and appears next cycle.
        applyStimulus(1, 3, 0, 0, 0, 0);
        #1;
        checkOutput("dec_ready_idle", int'(dec_ready), 1);
        expQ.push_back(3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("dec_state_prop", int'(state), int'(PROP));
        checkOutput("dec_empty", int'(ucq_empty), 0);
        checkOutput("dec_head", int'(lit_out), expQ[0]);
        dec_valid = 1'b1;
        #1;
        checkOutput("dec_ready_prop", int'(dec_ready), 0);
        dec_valid = 1'b0;

        // Same implication twice in a row is enqueued once.
        applyStimulus(0, 0, 1, -5, 0, 0);
        expQ.push_back(-5);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        popExpect("fifo_p3");
        popExpect("dup_m5");
        checkOutput("dup_once_empty", int'(ucq_empty), 1);

        // Out-of-range literals are ignored, the top index is accepted.
        applyStimulus(0, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, -32, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bad_lit_empty", int'(ucq_empty), 1);
        checkOutput("bad_lit_state", int'(state), int'(PROP));
        applyStimulus(0, 0, 1, 31, 0, 0);
        expQ.push_back(31);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        popExpect("max_idx");
        pe_idle = 1'b1;
        tick();
        checkOutput("prop_to_idle", int'(state), int'(IDLE));
        pe_idle = 1'b0;

        // Opposite polarity implication raises a conflict.
        applyStimulus(1, 2, 0, 0, 0, 0);
        expQ.push_back(2);
        tick();
        applyStimulus(0, 0, 1, -2, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        expQ.delete();
        checkOutput("opp_conflict", int'(conflict), 1);
        checkOutput("opp_state", int'(state), int'(CONFL));
        checkOutput("opp_empty", int'(ucq_empty), 1);
        checkOutput("opp_lit_out", int'(lit_out), 0);
        tick();
        checkOutput("confl_hold", int'(state), int'(CONFL));
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bt_clear", int'(state), int'(CLEAR));
        tick();
        checkOutput("bt_idle", int'(state), int'(IDLE));
        checkOutput("bt_conflict", int'(conflict), 0);
        applyStimulus(1, -2, 0, 0, 0, 0);
        #1;
        checkOutput("var2_free_ready", int'(dec_ready), 1);
        expQ.push_back(-2);
        tick();
        applyStimulus(0, 0, 1, -3, 0, 0);
        expQ.push_back(-3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("var2_free_conflict", int'(conflict), 0);
        popExpect("var2_free");
        popExpect("var3_free");
        doBacktrack();
        checkOutput("bt2_idle", int'(state), int'(IDLE));

        // Fill the queue, hold +5 while full, then let it in after one pop.
        applyStimulus(1, 1, 0, 0, 0, 0);
        expQ.push_back(1);
        tick();
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(0, 0, 1, i, 0, 0);
            expQ.push_back(i);
            tick();
        end
        applyStimulus(0, 0, 1, 5, 0, 0);
        #1;
        checkOutput("full_at_depth", int'(ucq_full), 1);
        tick();
        checkOutput("full_held", int'(ucq_full), 1);
        popExpect("order_1");
        checkOutput("full_after_pop", int'(ucq_full), 0);
        expQ.push_back(5);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_refill", int'(ucq_full), 1);
        for (int i = 2; i <= 5; i++) begin
            popExpect($sformatf("order_%0d", i));
        end
        checkOutput("order_drained", int'(ucq_empty), 1);

        // Push and pop together at count 2 keeps the count.
        applyStimulus(0, 0, 1, 6, 0, 0);
        expQ.push_back(6);
        tick();
        applyStimulus(0, 0, 1, 8, 0, 0);
        expQ.push_back(8);
        tick();
        applyStimulus(0, 0, 1, 9, 0, 0);
        expQ.push_back(9);
        popExpect("pushpop_6");
        applyStimulus(0, 0, 0, 0, 0, 0);
        popExpect("pushpop_8");
        checkOutput("pushpop_count2", int'(ucq_empty), 0);
        popExpect("pushpop_9");
        checkOutput("pushpop_drained", int'(ucq_empty), 1);

        // Backtrack beats a simultaneous implication.
        applyStimulus(0, 0, 1, 7, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bt_imply_state", int'(state), int'(CLEAR));
        checkOutput("bt_imply_empty", int'(ucq_empty), 1);
        tick();
        checkOutput("bt_imply_idle", int'(state), int'(IDLE));
        applyStimulus(1, -7, 0, 0, 0, 0);
        expQ.push_back(-7);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("var7_free_conflict", int'(conflict), 0);
        popExpect("var7_free");

        // Conflicting push together with pe_conflict enters CONFL once.
        applyStimulus(0, 0, 1, 7, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("dual_confl_state", int'(state), int'(CONFL));
        checkOutput("dual_confl_flag", int'(conflict), 1);
        tick();
        checkOutput("dual_confl_hold", int'(state), int'(CONFL));
        doBacktrack();
        checkOutput("bt3_idle", int'(state), int'(IDLE));

        // Reset in the middle of propagation with three literals queued.
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 2, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 3, 0, 0);
        tick();
        applyStimulus(1, 4, 0, 0, 0, 0);
        checkOutput("pre_rst_head", int'(lit_out), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dec_ready", int'(dec_ready), 0);
        checkOutput("midrst_empty", int'(ucq_empty), 1);
        checkOutput("midrst_lit_out", int'(lit_out), 0);
        checkOutput("midrst_full", int'(ucq_full), 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        expQ.delete();
        #1;
        checkOutput("postrst_empty", int'(ucq_empty), 1);
        checkOutput("postrst_state", int'(state), int'(IDLE));
        applyStimulus(1, 1, 0, 0, 0, 0);
        #1;
        checkOutput("postrst_ready", int'(dec_ready), 1);
        expQ.push_back(1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("postrst_state_prop", int'(state), int'(PROP));
        popExpect("postrst_fresh");
        checkOutput("postrst_no_residue", int'(ucq_empty), 1);

        checkOutput("sb_drain", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
